// File: rtl/gsens_tilt_filt_if.sv
// Sample handshake bundle for gsens_tilt_filt.
// The producer (master) drives the strobe, axis index and raw sample;
// the filter (slave) answers with oREADY.
interface gsens_tilt_filt_if #(
  parameter int N_AXES = 3,
  parameter int DATA_W = 10
);
  localparam int AX_W = (N_AXES > 1) ? $clog2(N_AXES) : 1;

  logic              iVALID;
  logic [AX_W-1:0]   iAXIS;
  logic [DATA_W-1:0] iDIG;
  logic              oREADY;

  modport master (output iVALID, output iAXIS, output iDIG, input oREADY);
  modport slave  (input iVALID, input iAXIS, input iDIG, output oREADY);
endinterface

// File: rtl/gsens_tilt_filt.sv
// gsens_tilt_filt: per-axis accelerometer window averager with range
// selection, optional hysteresis and held tilt magnitude/direction outputs.
// Optional feature: define GSENS_TILT_HYST_EN to only rewrite a held value
// when the new selected value moves by at least HYST_TH LSBs.
// Pipeline: sample edge -> stage 1 (average/select) -> stage 2 (hold).
// A range change on iG_INT2 flushes every axis window, one axis per cycle.
module gsens_tilt_filt #(
  parameter int N_AXES   = 3,
  parameter int DATA_W   = 10,
  parameter int AMT_W    = 4,
  parameter int AVG_LOG2 = 2,
  parameter int HYST_TH  = 2
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic                    iG_INT2,
  gsens_tilt_filt_if.slave        smp,
  output logic [N_AXES*AMT_W-1:0] tilt_amount,
  output logic [N_AXES-1:0]       tilt_direction,
  output logic [N_AXES-1:0]       oUPD,
  output logic                    oERR
);
  localparam int AX_W  = (N_AXES > 1) ? $clog2(N_AXES) : 1;
  localparam int S     = AMT_W + 1;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [AX_W:0]    N_AX_L   = (AX_W + 1)'(N_AXES);
  localparam logic [AX_W-1:0]  AX_LAST  = AX_W'(N_AXES - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                  state;
  logic                    ready_q;
  logic                    range_q;
  logic [AX_W-1:0]         flush_idx;
  logic signed [ACC_W-1:0] acc [N_AXES];
  logic [CNT_W-1:0]        cnt [N_AXES];
  logic                    s1_vld;
  logic [AX_W-1:0]         s1_axis;
  logic signed [S-1:0]     s1_val;
  logic signed [S-1:0]     held [N_AXES];
  logic [N_AXES-1:0]       upd_q;
  logic                    err_q;

  logic                    accept;
  logic                    ax_ok;
  logic [AX_W-1:0]         ax_idx;
  logic                    range_chg;
  logic                    take_smp;
  logic                    take_res;
  logic signed [ACC_W-1:0] sum_c;
  logic [DATA_W-1:0]       avg_c;
  logic                    win_done_c;
  logic signed [S-1:0]     sel_c;
`ifdef GSENS_TILT_HYST_EN
  logic signed [S:0]       diff_c;
  logic [S:0]              mag_c;
`endif

  assign accept    = smp.iVALID && ready_q;
  assign ax_ok     = {1'b0, smp.iAXIS} < N_AX_L;
  assign ax_idx    = ax_ok ? smp.iAXIS : '0;
  assign range_chg = iG_INT2 != range_q;
  assign take_smp  = accept && ax_ok && (state == RUN) && !range_chg;

  assign smp.oREADY = ready_q;
  assign oUPD       = upd_q;
  assign oERR       = err_q;

  // Accumulate the incoming sample, form the window average and pick the range-dependent bits.
  always_comb begin
    sum_c      = acc[ax_idx] + ACC_W'($signed(smp.iDIG));
    avg_c      = DATA_W'(sum_c >>> AVG_LOG2);
    win_done_c = cnt[ax_idx] == CNT_LAST;
    sel_c      = '0;
    if (range_q) begin
      sel_c = avg_c[DATA_W-1 -: S];
    end else if (avg_c[DATA_W-1] == avg_c[DATA_W-2]) begin
      sel_c = avg_c[DATA_W-2 -: S];
    end else if (!avg_c[DATA_W-1]) begin
      sel_c = {1'b0, {AMT_W{1'b1}}};
    end else begin
      sel_c = {1'b1, {AMT_W{1'b0}}};
    end
  end

  // Decide whether the stage-1 result may overwrite the held value of its axis.
  always_comb begin
`ifdef GSENS_TILT_HYST_EN
    diff_c   = (S + 1)'(s1_val) - (S + 1)'(held[s1_axis]);
    mag_c    = diff_c[S] ? -diff_c : diff_c;
    take_res = int'(mag_c) >= HYST_TH;
`else
    take_res = 1'b1;
`endif
  end

  // Turn each held signed value into a direction bit and a saturated magnitude.
  always_comb begin
    tilt_amount    = '0;
    tilt_direction = '0;
    for (int k = 0; k < N_AXES; k++) begin
      tilt_direction[k] = held[k][S-1];
      if (!held[k][S-1]) begin
        tilt_amount[k*AMT_W +: AMT_W] = held[k][AMT_W-1:0];
      end else if (held[k] == {1'b1, {AMT_W{1'b0}}}) begin
        tilt_amount[k*AMT_W +: AMT_W] = '1;
      end else begin
        tilt_amount[k*AMT_W +: AMT_W] = AMT_W'(-held[k]);
      end
    end
  end

  // RUN/FLUSH controller together with the accumulators, pipeline and held values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= RUN;
      ready_q   <= 1'b1;
      range_q   <= 1'b0;
      flush_idx <= '0;
      s1_vld    <= 1'b0;
      s1_axis   <= '0;
      s1_val    <= '0;
      upd_q     <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k < N_AXES; k++) begin
        acc[k]  <= '0;
        cnt[k]  <= '0;
        held[k] <= '0;
      end
    end else begin
      upd_q  <= '0;
      err_q  <= accept && !ax_ok;
      s1_vld <= 1'b0;
      case (state)
        RUN: begin
          if (range_chg) begin
            state     <= FLUSH;
            ready_q   <= 1'b0;
            range_q   <= iG_INT2;
            flush_idx <= '0;
          end else begin
            if (take_smp) begin
              if (win_done_c) begin
                acc[ax_idx] <= '0;
                cnt[ax_idx] <= '0;
                s1_vld      <= 1'b1;
                s1_axis     <= ax_idx;
                s1_val      <= sel_c;
              end else begin
                acc[ax_idx] <= sum_c;
                cnt[ax_idx] <= cnt[ax_idx] + 1'b1;
              end
            end
            if (s1_vld && take_res) begin
              held[s1_axis]  <= s1_val;
              upd_q[s1_axis] <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (range_chg) begin
            range_q   <= iG_INT2;
            flush_idx <= '0;
          end else begin
            acc[flush_idx] <= '0;
            cnt[flush_idx] <= '0;
            if (flush_idx == AX_LAST) begin
              state   <= RUN;
              ready_q <= 1'b1;
            end else begin
              flush_idx <= flush_idx + 1'b1;
            end
          end
        end
        default: begin
          state   <= RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/gsens_tilt_filt.md
GSENS_TILT_FILT -- requirements
Module: gsens_tilt_filt

Interface
REQ-001 SHALL have parameter N_AXES, default 3: number of accelerometer axes tracked (1..8).
REQ-002 SHALL have parameter DATA_W, default 10: raw sample width, two's complement (8..16).
REQ-003 SHALL have parameter AMT_W, default 4: tilt magnitude width; selected signed value width S = AMT_W+1 (S <= DATA_W-1).
REQ-004 SHALL have parameter AVG_LOG2, default 2: window of 2^AVG_LOG2 samples per axis (0..4).
REQ-005 SHALL have parameter HYST_TH, default 2: hysteresis threshold in S-bit LSBs.
REQ-006 SHALL have port iCLK, input, 1: single clock; all logic is on the rising edge.
REQ-007 SHALL have port iRST_N, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port iVALID, input, 1: sample strobe.
REQ-009 SHALL have port iAXIS, input, AX_W = max(1,clog2(N_AXES)): axis index of the sample.
REQ-010 SHALL have port iDIG, input, DATA_W: raw sample.
REQ-011 SHALL have port iG_INT2, input, 1: 1 = +-2g (full DATA_W resolution), 0 = +-g (DATA_W-1 resolution).
REQ-012 SHALL have port oREADY, output, 1: sample accepted when iVALID and oREADY are both high.
REQ-013 SHALL have port tilt_amount, output, N_AXES*AMT_W: per-axis magnitude; axis k is at [k*AMT_W +: AMT_W].
REQ-014 SHALL have port tilt_direction, output, N_AXES: per-axis sign; 1 = negative.
REQ-015 SHALL have port oUPD, output, N_AXES: one-cycle pulse when the held value of the axis is rewritten.
REQ-016 SHALL have port oERR, output, 1: one-cycle pulse when an accepted sample has iAXIS >= N_AXES.

Function
REQ-017 SHALL keep, per axis, a DATA_W+AVG_LOG2 signed accumulator and a sample counter; an accepted sample adds sign-extended iDIG to the accumulator.
REQ-018 When the counter reaches 2^AVG_LOG2, the average SHALL be the accumulator arithmetic-shifted right by AVG_LOG2 (floor); the accumulator and counter SHALL then clear for the next window.
REQ-019 Mode 1: the selected value SHALL be avg[DATA_W-1 -: S].
REQ-020 Mode 0, top two bits equal: the selected value SHALL be avg[DATA_W-2 -: S].
REQ-021 Mode 0, top two bits differ: the selected value SHALL saturate to +max (0 followed by all 1s) when avg is positive, and to -2^(S-1) when avg is negative.
REQ-022 tilt_direction SHALL equal the sign of the held value; tilt_amount SHALL equal |held| saturated to 2^AMT_W-1, so -16 gives 15, never 0.
REQ-023 Latency: a sample that completes a window in cycle t SHALL produce its outputs and oUPD in cycle t+2 (stage 1: average/select; stage 2: hysteresis/hold).
REQ-024 Back-to-back samples on the same or different axes SHALL be accepted every cycle while oREADY = 1, with no loss.
REQ-025 FSM states SHALL be RUN and FLUSH.
REQ-026 In RUN, oREADY SHALL be 1.
REQ-027 A registered copy of iG_INT2 SHALL be kept; when iG_INT2 differs from that copy while in RUN, the FSM SHALL enter FLUSH.
REQ-028 FLUSH SHALL last exactly N_AXES cycles, clearing one axis accumulator/counter per cycle, with oREADY = 0; the FSM SHALL then return to RUN.
REQ-029 Samples presented during FLUSH SHALL be ignored.
REQ-030 A pipeline result in flight at FLUSH entry SHALL be discarded: no oUPD and held value unchanged.
REQ-031 Held outputs SHALL be retained across FLUSH.
REQ-032 A range change during FLUSH SHALL update the copy and restart the FLUSH count.
REQ-033 An accepted sample with an invalid axis SHALL pulse oERR one cycle later and SHALL change no other state.

Reset
REQ-034 While iRST_N is low, all accumulators, counters, pipeline valids and held values SHALL be 0, and the range copy SHALL be 0.
REQ-035 During reset, the outputs SHALL be tilt_amount = 0, tilt_direction = 0, oUPD = 0, oERR = 0, oREADY = 1, and the FSM SHALL be in RUN.
REQ-036 Reset asserted mid-window or mid-FLUSH SHALL abort immediately, with no pulses.
REQ-037 iG_INT2 = 1 at reset release SHALL cause one FLUSH.

Configuration
REQ-038 With macro GSENS_TILT_HYST_EN defined, a new selected value v SHALL replace held h only when |v-h| >= HYST_TH, and oUPD SHALL pulse only on replacement.
REQ-039 Without GSENS_TILT_HYST_EN, every completed window SHALL replace held, and oUPD SHALL pulse for every window; HYST_TH SHALL be unused.

Verification (N_AXES=3, DATA_W=10, AMT_W=4, AVG_LOG2=2, HYST_TH=2)
REQ-040 Mode 1, axis0, 4x 10'h0A0 -> axis0 amount=5, dir=0, oUPD[0] pulse 2 cycles after the 4th sample.
REQ-041 Mode 0, axis2, 4x 10'h3C0 -> amount=4, dir=1; a further 4x 10'h100 -> amount=15, dir=0; a further 4x 10'h200 -> amount=15, dir=1.
REQ-042 Held +5 on axis0, window averaging 10'h0C0 in mode 1 (+6) -> with GSENS_TILT_HYST_EN: no oUPD, amount stays 5; without it: amount=6 with oUPD pulse.
REQ-043 2 samples on axis1, then iG_INT2 toggled -> oREADY=0 for exactly 3 cycles, then 4 new samples form a fresh window, and only then does oUPD[1] pulse.
REQ-044 Accepted sample with iAXIS=3 -> oERR pulse next cycle; no oUPD, no counter change.
REQ-045 iRST_N asserted after 3 samples on axis0 and then released -> all outputs 0, and 4 new samples are required before oUPD[0].
